// File: rtl/ptp_us_sync_multi.sv
// Ultrasonic TX burst and multi-channel RX timestamp capture on an Avalon-MM slave; 1-cycle read latency, never stalls.
// Optional feature: define PTP_US_OFFSET_EN to enable the one-shot signed TIME correction through OFFSET (0x20).
module ptp_us_sync_multi #(
  parameter int CHANNELS    = 4,
  parameter int TS_WIDTH    = 32,
  parameter int HALF_PERIOD = 1250,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT     = 2500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         avalon_slave_address,
  input  logic                avalon_slave_write,
  input  logic [31:0]         avalon_slave_writedata,
  input  logic                avalon_slave_read,
  output logic [31:0]         avalon_slave_readdata,
  output logic                avalon_slave_waitrequest,
  output logic                piezo_interface_out,
  input  logic [CHANNELS-1:0] piezo_interface_in
);
  localparam int HP_W = $clog2(HALF_PERIOD + 1);
  localparam int HC_W = $clog2(2 * BURST_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, TX, LISTEN, DONE} state_t;

  state_t              state;
  logic [TS_WIDTH-1:0] time_cnt;
  logic [TS_WIDTH-1:0] tx_ts;
  logic [TS_WIDTH-1:0] rx_ts [CHANNELS];
  logic [CHANNELS-1:0] flags;
  logic [CHANNELS-1:0] sync1, sync2, sync3;
  logic [CHANNELS-1:0] edges;
  logic [CHANNELS-1:0] new_flags;
  logic                timeout_flag;
  logic [HP_W-1:0]     hp_cnt;
  logic [HC_W-1:0]     half_cnt;
  logic [TO_W-1:0]     lst_cnt;
  logic                ctrl_wr;
  logic                start;
  logic                abort;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign avalon_slave_waitrequest = 1'b0;
  assign unused_bits = ^avalon_slave_writedata[31:2];

  assign ctrl_wr = avalon_slave_write && (avalon_slave_address == 16'd0);
  assign abort   = ctrl_wr && avalon_slave_writedata[1];
  assign start   = ctrl_wr && avalon_slave_writedata[0] && !avalon_slave_writedata[1];

  assign edges     = sync2 & ~sync3;
  assign new_flags = flags | (edges & {CHANNELS{state == LISTEN}});

`ifdef PTP_US_OFFSET_EN
  logic [31:0] offset_reg;
  logic        offset_wr;

  assign offset_wr = avalon_slave_write && (avalon_slave_address == 16'h0020);

  // Captures and TX latch in the correction cycle see the pre-correction time_cnt.
  always_ff @(posedge clock) begin
    if (reset) begin
      time_cnt   <= '0;
      offset_reg <= '0;
    end else if (offset_wr) begin
      time_cnt   <= time_cnt + TS_WIDTH'(1) + avalon_slave_writedata[TS_WIDTH-1:0];
      offset_reg <= avalon_slave_writedata;
    end else begin
      time_cnt <= time_cnt + TS_WIDTH'(1);
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) time_cnt <= '0;
    else       time_cnt <= time_cnt + TS_WIDTH'(1);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= piezo_interface_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      piezo_interface_out <= 1'b0;
      tx_ts               <= '0;
      flags               <= '0;
      timeout_flag        <= 1'b0;
      hp_cnt              <= '0;
      half_cnt            <= '0;
      lst_cnt             <= '0;
      for (int c = 0; c < CHANNELS; c++) rx_ts[c] <= '0;
    end else if (abort) begin
      state               <= IDLE;
      piezo_interface_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state               <= TX;
            piezo_interface_out <= 1'b1;
            tx_ts               <= time_cnt;
            flags               <= '0;
            timeout_flag        <= 1'b0;
            hp_cnt              <= '0;
            half_cnt            <= '0;
            for (int c = 0; c < CHANNELS; c++) rx_ts[c] <= '0;
          end
        end
        TX: begin
          if (hp_cnt == HP_W'(HALF_PERIOD - 1)) begin
            hp_cnt <= '0;
            if (half_cnt == HC_W'(2 * BURST_LEN - 1)) begin
              state               <= LISTEN;
              piezo_interface_out <= 1'b0;
              lst_cnt             <= '0;
            end else begin
              half_cnt            <= half_cnt + HC_W'(1);
              piezo_interface_out <= ~piezo_interface_out;
            end
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end
        end
        LISTEN: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (edges[c] && !flags[c]) rx_ts[c] <= time_cnt;
          end
          flags <= new_flags;
          // Completing the last channel on the final window cycle is not a timeout.
          if (&new_flags) begin
            state <= DONE;
          end else if (lst_cnt == TO_W'(TIMEOUT - 1)) begin
            state        <= DONE;
            timeout_flag <= 1'b1;
          end else begin
            lst_cnt <= lst_cnt + TO_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avalon_slave_address)
      16'd1: begin
        rd_mux[0]             = (state != IDLE);
        rd_mux[1]             = timeout_flag;
        rd_mux[2 +: CHANNELS] = flags;
      end
      16'd2: rd_mux[TS_WIDTH-1:0] = time_cnt;
      16'd3: rd_mux[TS_WIDTH-1:0] = tx_ts;
`ifdef PTP_US_OFFSET_EN
      16'h0020: rd_mux = offset_reg;
`endif
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (avalon_slave_address == 16'(4 + c)) rd_mux[TS_WIDTH-1:0] = rx_ts[c];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                  avalon_slave_readdata <= '0;
    else if (avalon_slave_read) avalon_slave_readdata <= rd_mux;
  end
endmodule

// File: tb/tb_ptp_us_sync_multi.sv
// Directed bench for ptp_us_sync_multi: 8-bit timestamps, 4-cycle half-period, 2-period bursts, 1000-cycle window.
module tb_ptp_us_sync_multi;
  localparam int CH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        out;
  logic [CH-1:0] piezo_in = '0;
  logic [7:0]  mtime;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] want;
    bit          rel;
  } vec_t;
  vec_t vt [9];

  ptp_us_sync_multi #(
    .CHANNELS(CH), .TS_WIDTH(8), .HALF_PERIOD(4), .BURST_LEN(2), .TIMEOUT(1000)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .avalon_slave_address    (address),
    .avalon_slave_write      (write),
    .avalon_slave_writedata  (writedata),
    .avalon_slave_read       (read),
    .avalon_slave_readdata   (readdata),
    .avalon_slave_waitrequest(waitrequest),
    .piezo_interface_out     (out),
    .piezo_interface_in      (piezo_in)
  );

  always #5 clock = ~clock;

  // Reference time base: counts cycles since reset release, modulo 256.
  always @(posedge clock) begin
    if (reset) mtime <= 8'd0;
    else       mtime <= mtime + 8'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(posedge clock); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
    end
  endtask

  initial begin
    logic [7:0]  t;
    logic [31:0] r, r2;

    vt[0] = '{16'd3,  32'd0,   1'b1};
    vt[1] = '{16'd4,  32'd118, 1'b1};
    vt[2] = '{16'd5,  32'd0,   1'b0};
    vt[3] = '{16'd6,  32'd12,  1'b1};
    vt[4] = '{16'd7,  32'd0,   1'b0};
    vt[5] = '{16'd1,  32'h16,  1'b0};
    vt[6] = '{16'd0,  32'd0,   1'b0};
    vt[7] = '{16'd8,  32'd0,   1'b0};
    vt[8] = '{16'h10, 32'd0,   1'b0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("waitrequest", 32'(waitrequest), 32'd0);

    t = mtime;
    rd(16'd2, r);
    chk("time_read", r, {24'd0, t});
    repeat (9) tick();
    rd(16'd2, r2);
    chk("time_delta", r2 - r, 32'd10);
    rd(16'd1, r);
    chk("status_idle", r, 32'd0);

    // Burst shape, busy timing, two captures and window timeout.
    t = mtime;
    wr(16'd0, 32'd1);
    for (int i = 0; i < 1020; i++) begin
      if (i < 20) chk("burst_out", 32'(out), (i < 16 && (i / 4) % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 115) piezo_in[0] = 1'b1;
      if (i == 265) piezo_in[2] = 1'b1;
      if (i == 0 || i == 1015 || i == 1016 || i == 1017) begin
        rd(16'd1, r);
        chk($sformatf("status_c%0d", i), r,
            (i == 0) ? 32'h01 : (i == 1015) ? 32'h15 : (i == 1016) ? 32'h17 : 32'h16);
      end else begin
        tick();
      end
    end
    piezo_in = '0;
    for (int k = 0; k < 9; k++) begin
      rd(vt[k].addr, r);
      chk($sformatf("reg_%0h", vt[k].addr), r,
          vt[k].rel ? {24'd0, t + vt[k].want[7:0]} : vt[k].want);
    end

    // TX blanking, START while busy, all channels at LISTEN cycle 4.
    repeat (4) tick();
    t = mtime;
    wr(16'd0, 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (i >= 2 && i <= 12) piezo_in = i[0] ? 4'hF : 4'h0;
      if (i == 13) piezo_in = 4'h0;
      if (i == 20) piezo_in = 4'hF;
      if (i == 6) chk("busy_start_ignored_out", 32'(out), 32'd0);
      if (i == 5) begin
        wr(16'd0, 32'd1);
      end else if (i == 0 || i == 14 || i == 23 || i == 24) begin
        rd(16'd1, r);
        chk($sformatf("blank_status_c%0d", i), r,
            (i == 23) ? 32'h3D : (i == 24) ? 32'h3C : 32'h01);
      end else begin
        tick();
      end
    end
    rd(16'd3, r);
    chk("blank_tx_ts", r, {24'd0, t});
    for (int c = 0; c < CH; c++) begin
      rd(16'(4 + c), r);
      chk($sformatf("blank_rx_ts%0d", c), r, {24'd0, t + 8'd23});
    end

    // Last channel lands on the final window cycle: flags win over timeout.
    piezo_in = '0;
    repeat (4) tick();
    wr(16'd0, 32'd1);
    for (int i = 0; i < 1020; i++) begin
      if (i == 1013) piezo_in = 4'hF;
      if (i == 1016) begin
        rd(16'd1, r);
        chk("flags_win_status", r, 32'h3D);
      end else begin
        tick();
      end
    end

    // One cycle later the window has already closed.
    piezo_in = '0;
    repeat (4) tick();
    wr(16'd0, 32'd1);
    for (int i = 0; i < 1020; i++) begin
      if (i == 1014) piezo_in = 4'hF;
      if (i == 1016 || i == 1017) begin
        rd(16'd1, r);
        chk($sformatf("late_status_c%0d", i), r, (i == 1016) ? 32'h03 : 32'h02);
      end else begin
        tick();
      end
    end

    // Counter wrap at 8 bits, then ABORT in LISTEN keeps captures.
    piezo_in = '0;
    repeat (4) tick();
    while (mtime != 8'd250) tick();
    wr(16'd0, 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (i == 20) piezo_in[1] = 1'b1;
      if (i == 26) begin
        wr(16'd0, 32'd2);
      end else if (i == 27) begin
        chk("abort_listen_out", 32'(out), 32'd0);
        rd(16'd1, r);
        chk("abort_listen_status", r, 32'h08);
      end else begin
        tick();
      end
    end
    rd(16'd3, r);
    chk("wrap_tx_ts", r, 32'd250);
    rd(16'd5, r);
    chk("wrap_rx_ts1", r, 32'd17);
    rd(16'd4, r);
    chk("wrap_rx_ts0_cleared", r, 32'd0);

    // ABORT mid-burst drops the output next cycle.
    piezo_in = '0;
    repeat (4) tick();
    wr(16'd0, 32'd1);
    for (int i = 0; i < 14; i++) begin
      if (i == 8) chk("abort_tx_out_before", 32'(out), 32'd1);
      if (i == 10) chk("abort_tx_out_after", 32'(out), 32'd0);
      if (i == 9) begin
        wr(16'd0, 32'd2);
      end else if (i == 11) begin
        rd(16'd1, r);
        chk("abort_tx_status", r, 32'd0);
      end else begin
        tick();
      end
    end

    wr(16'd0, 32'd3);
    rd(16'd1, r);
    chk("start_abort_status", r, 32'd0);
    chk("start_abort_out", 32'(out), 32'd0);

`ifdef PTP_US_OFFSET_EN
    while (mtime != 8'd200) tick();
    wr(16'h20, -32'sd100);
    rd(16'd2, r);
    chk("offset_time", r, 32'd101);
    rd(16'h20, r);
    chk("offset_read", r, 32'hFFFF_FF9C);
`else
    wr(16'h20, 32'h55);
    rd(16'h20, r);
    chk("offset_read_zero", r, 32'd0);
    t = mtime;
    rd(16'd2, r);
    chk("offset_time_untouched", r, {24'd0, t});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
